// File: rtl/nf10_upb_reset_seq_pkg.sv
// Shared definitions for the NetFPGA-10G UPB reset sequencer.
//
// Contents:
//   seq_state_t  - sequencer state encoding (also exported for debug)
//   CNT_W        - width of the shared cycle counter
//   FSTG_W       - width of the fault_stage / stage index fields
//   last_index() - index of the final stage for a given stage count
package nf10_upb_reset_seq_pkg;

    localparam int CNT_W  = 16;
    localparam int FSTG_W = 3;

    typedef enum logic [2:0] {
        ST_HOLD     = 3'd0,
        ST_RELEASE  = 3'd1,
        ST_WAIT_RDY = 3'd2,
        ST_RUN      = 3'd3,
        ST_FAULT    = 3'd4
    } seq_state_t;

    // Index of the last sequenced stage (num_stages is 1..8).
    function automatic logic [FSTG_W-1:0] last_index(input int num_stages);
        return FSTG_W'(num_stages - 1);
    endfunction

endpackage

// File: rtl/nf10_upb_reset_seq_timer.sv
// Cycle counter shared by the hold phase and the per-stage ready timeout.
//
// Ports:
//   clk, reset_n - clock and synchronous active-low reset
//   clear        - force the count to zero (wins over enable)
//   enable       - advance the count by one this cycle
//   limit        - terminal count value, supplied at run time
//   done         - high while the count equals limit
module nf10_upb_reset_seq_timer
    import nf10_upb_reset_seq_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // The caller programs limit as (cycles - 1), so done is seen on the
    // last cycle of the window and the caller leaves on that same edge.
    assign done = (count == limit);

endmodule

// File: rtl/nf10_upb_reset_sequencer.sv
// Reset sequencer: holds every stage in reset for HOLD_CYCLES, then releases
// the stages one at a time, waiting for each stage_ready before releasing the
// next. A stage that never becomes ready, or any stage dropping ready once the
// whole chain is running, latches a sticky fault and re-resets every stage.
//
// Ports:
//   clk            - single clock, rising edge
//   reset_n        - synchronous active-low reset, overrides everything
//   soft_reset_req - level request to restart from the hold phase
//   stage_ready    - per-stage initialised flags (clk domain)
//   stage_reset_n  - registered active-low reset per stage
//   all_ready      - every stage released and ready (registered)
//   fault          - sticky error flag
//   fault_stage    - index of the stage that caused the fault
//   seq_state      - current sequencer state, for debug visibility
module nf10_upb_reset_sequencer
    import nf10_upb_reset_seq_pkg::*;
#(
    parameter int NUM_STAGES     = 4,
    parameter int HOLD_CYCLES    = 2048,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  soft_reset_req,
    input  logic [NUM_STAGES-1:0] stage_ready,
    output logic [NUM_STAGES-1:0] stage_reset_n,
    output logic                  all_ready,
    output logic                  fault,
    output logic [FSTG_W-1:0]     fault_stage,
    output logic [2:0]            seq_state
);

    localparam logic [CNT_W-1:0]  HOLD_LIMIT    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FSTG_W-1:0] LAST_IDX      = last_index(NUM_STAGES);

    seq_state_t              state, state_d;
    logic [FSTG_W-1:0]       idx, idx_d;
    // Stages whose release has been committed; copied to stage_reset_n one
    // edge later, which gives the two-cycle ready-to-next-release spacing.
    logic [NUM_STAGES-1:0]   released, released_d;
    logic [NUM_STAGES-1:0]   stage_reset_n_d;
    logic                    all_ready_d;
    logic                    fault_d;
    logic [FSTG_W-1:0]       fault_stage_d;

    logic                    tmr_clear;
    logic                    tmr_en;
    logic [CNT_W-1:0]        tmr_limit;
    logic                    tmr_done;

    logic                    ready_sel;
    logic                    any_low;
    logic [FSTG_W-1:0]       low_idx;

    nf10_upb_reset_seq_timer u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (tmr_clear),
        .enable  (tmr_en),
        .limit   (tmr_limit),
        .done    (tmr_done)
    );

    // Ready flag of the stage currently being waited on. Only this bit is
    // looked at while sequencing, so unreleased stages cannot advance it.
    always_comb begin
        ready_sel = 1'b0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (idx == FSTG_W'(i)) begin
                ready_sel = stage_ready[i];
            end
        end
    end

    // Lowest-numbered stage whose ready is low (scan downwards so the
    // lowest match is the one that sticks).
    always_comb begin
        any_low = 1'b0;
        low_idx = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (!stage_ready[i]) begin
                any_low = 1'b1;
                low_idx = FSTG_W'(i);
            end
        end
    end

    always_comb begin
        state_d       = state;
        idx_d         = idx;
        released_d    = released;
        fault_d       = fault;
        fault_stage_d = fault_stage;
        tmr_clear     = 1'b0;
        tmr_en        = 1'b0;
        tmr_limit     = HOLD_LIMIT;

        case (state)
            ST_HOLD: begin
                tmr_limit = HOLD_LIMIT;
                if (tmr_done) begin
                    state_d   = ST_RELEASE;
                    idx_d     = '0;
                    tmr_clear = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end

            ST_RELEASE: begin
                for (int i = 0; i < NUM_STAGES; i++) begin
                    if (idx == FSTG_W'(i)) begin
                        released_d[i] = 1'b1;
                    end
                end
                tmr_clear = 1'b1;
                state_d   = ST_WAIT_RDY;
            end

            ST_WAIT_RDY: begin
                tmr_limit = TIMEOUT_LIMIT;
                // Ready is tested before the timeout so that a ready seen on
                // the final timeout cycle still advances the sequence.
                if (ready_sel) begin
                    if (idx == LAST_IDX) begin
                        state_d = ST_RUN;
                    end else begin
                        idx_d   = idx + 1'b1;
                        state_d = ST_RELEASE;
                    end
                end else if (tmr_done) begin
                    state_d       = ST_FAULT;
                    fault_d       = 1'b1;
                    fault_stage_d = idx;
                end else begin
                    tmr_en = 1'b1;
                end
            end

            ST_RUN: begin
                if (any_low) begin
                    state_d       = ST_FAULT;
                    fault_d       = 1'b1;
                    fault_stage_d = low_idx;
                end
            end

            ST_FAULT: begin
                state_d = ST_FAULT;
            end

            default: begin
                state_d = ST_HOLD;
            end
        endcase

        // Soft restart beats every transition above; holding it high keeps
        // the hold counter pinned at zero.
        if (soft_reset_req) begin
            state_d       = ST_HOLD;
            idx_d         = '0;
            released_d    = '0;
            fault_d       = 1'b0;
            fault_stage_d = '0;
            tmr_clear     = 1'b1;
            tmr_en        = 1'b0;
        end

        // Entering HOLD or FAULT drops every stage on the same edge.
        if (state_d == ST_HOLD || state_d == ST_FAULT) begin
            stage_reset_n_d = '0;
        end else begin
            stage_reset_n_d = released;
        end

        all_ready_d = (state == ST_RUN) && (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= ST_HOLD;
            idx           <= '0;
            released      <= '0;
            stage_reset_n <= '0;
            all_ready     <= 1'b0;
            fault         <= 1'b0;
            fault_stage   <= '0;
        end else begin
            state         <= state_d;
            idx           <= idx_d;
            released      <= released_d;
            stage_reset_n <= stage_reset_n_d;
            all_ready     <= all_ready_d;
            fault         <= fault_d;
            fault_stage   <= fault_stage_d;
        end
    end

    assign seq_state = state;

endmodule

// File: tb/tb_nf10_upb_reset_sequencer.sv
// Bench for nf10_upb_reset_sequencer (3 stages, hold 16, timeout 32).
// The reference model is a timeline: from the per-stage ready delays it
// computes the edge on which each stage is released, the run edge and the
// fault edge, and derives the expected outputs for any edge number.
module tb_nf10_upb_reset_sequencer;

    localparam int N     = 3;
    localparam int H     = 16;
    localparam int T     = 32;
    localparam int NEVER = 100000;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         soft_reset_req = 1'b0;
    logic [N-1:0] stage_ready = '0;
    logic [N-1:0] stage_reset_n;
    logic         all_ready;
    logic         fault;
    logic [2:0]   fault_stage;
    logic [2:0]   seq_state;
    logic [7:0]   obs;

    int total = 0;
    int bad   = 0;

    // timeline model
    int         dly [N];
    int         rise [N];
    int         rdy_at [N];
    int         fault_at;
    int         fault_stg;
    int         run_at;
    int         drop_at;
    logic [N-1:0] drop_mask;

    nf10_upb_reset_sequencer #(
        .NUM_STAGES     (N),
        .HOLD_CYCLES    (H),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .soft_reset_req (soft_reset_req),
        .stage_ready    (stage_ready),
        .stage_reset_n  (stage_reset_n),
        .all_ready      (all_ready),
        .fault          (fault),
        .fault_stage    (fault_stage),
        .seq_state      (seq_state)
    );

    assign obs = {stage_reset_n, all_ready, fault, fault_stage};

    always #5 clk = ~clk;

    // Edge 0 is the last edge with reset_n low or soft_reset_req high.
    // Stage 0 releases H+2 edges later; stage i+1 releases 2 edges after
    // stage i's ready is first sampled; a stage not ready within T sampled
    // edges faults on the T-th one. drop_off > 0 drops the ready bits in
    // dmask that many edges after entering run.
    function automatic void plan(input int d0, input int d1, input int d2,
                                 input int drop_off, input logic [N-1:0] dmask);
        int t;
        dly       = '{d0, d1, d2};
        fault_at  = NEVER;
        fault_stg = 0;
        run_at    = NEVER;
        drop_at   = NEVER;
        drop_mask = dmask;
        for (int i = 0; i < N; i++) begin
            rise[i]   = NEVER;
            rdy_at[i] = NEVER;
        end
        t = H + 2;
        for (int i = 0; i < N; i++) begin
            rise[i] = t;
            if (dly[i] > T - 1) begin
                fault_at  = t + T - 1;
                fault_stg = i;
                break;
            end
            rdy_at[i] = t + dly[i];
            t = rdy_at[i] + 2;
        end
        if (fault_at == NEVER) begin
            run_at = rdy_at[N-1];
            if (dmask != '0) begin
                drop_at  = run_at + drop_off;
                fault_at = drop_at;
                for (int i = 0; i < N; i++) begin
                    if (dmask[i]) begin
                        fault_stg = i;
                        break;
                    end
                end
            end
        end
    endfunction

    function automatic logic [7:0] expect_at(input int t);
        logic [N-1:0] sr;
        logic         ar;
        logic         f;
        logic [2:0]   fs;
        for (int i = 0; i < N; i++) begin
            sr[i] = (t >= rise[i]) && (t < fault_at);
        end
        ar = (t >= run_at + 1) && (t < fault_at);
        f  = (t >= fault_at);
        fs = f ? 3'(fault_stg) : 3'd0;
        return {sr, ar, f, fs};
    endfunction

    // Ready bits of stages not yet being waited on are random noise.
    function automatic logic [N-1:0] ready_at(input int t);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) begin
            if (t < rise[i]) begin
                r[i] = 1'($urandom_range(0, 1));
            end else begin
                r[i] = (t >= rdy_at[i]) && !(drop_mask[i] && t >= drop_at);
            end
        end
        return r;
    endfunction

    function automatic int last_edge();
        return ((fault_at != NEVER) ? fault_at : run_at) + 10;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step(input int t);
        @(negedge clk);
        reset_n        = 1'b1;
        soft_reset_req = 1'b0;
        stage_ready    = ready_at(t);
        @(posedge clk);
        #1;
    endtask

    task automatic start_by_reset();
        @(negedge clk);
        reset_n        = 1'b0;
        soft_reset_req = 1'($urandom_range(0, 1));
        stage_ready    = N'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic start_by_soft();
        @(negedge clk);
        reset_n        = 1'b1;
        soft_reset_req = 1'b1;
        stage_ready    = N'($urandom);
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin
            start_by_reset();
            total++;
            if (obs !== 8'h00) begin
                bad++;
                $display("FAIL reset k=%0d got=%b exp=%b", k, obs, 8'h00);
            end
        end
    endtask

    task automatic test_normal();
        start_by_reset();
        plan(5, 5, 5, 0, '0);
        for (int t = 1; t <= last_edge(); t++) begin
            step(t);
            total++;
            if (obs !== expect_at(t)) begin
                bad++;
                $display("FAIL normal t=%0d got=%b exp=%b", t, obs, expect_at(t));
            end
        end
    endtask

    task automatic test_timeout();
        start_by_reset();
        plan(5, 200, 5, 0, '0);
        for (int t = 1; t <= last_edge(); t++) begin
            step(t);
            total++;
            if (obs !== expect_at(t)) begin
                bad++;
                $display("FAIL timeout t=%0d got=%b exp=%b", t, obs, expect_at(t));
            end
        end
    endtask

    task automatic test_boundary();
        start_by_reset();
        plan(4, T - 1, 3, 0, '0);
        for (int t = 1; t <= last_edge(); t++) begin
            step(t);
            total++;
            if (obs !== expect_at(t)) begin
                bad++;
                $display("FAIL boundary t=%0d got=%b exp=%b", t, obs, expect_at(t));
            end
        end
    endtask

    task automatic test_runtime_drop();
        start_by_reset();
        plan(5, 5, 5, 3, 3'b101);
        for (int t = 1; t <= last_edge(); t++) begin
            step(t);
            total++;
            if (obs !== expect_at(t)) begin
                bad++;
                $display("FAIL drop t=%0d got=%b exp=%b", t, obs, expect_at(t));
            end
        end
    endtask

    // Runs while the DUT is still latched in the fault left by the drop test.
    task automatic test_recovery();
        total++;
        if (fault !== 1'b1) begin
            bad++;
            $display("FAIL recovery_pre got=%b exp=%b", fault, 1'b1);
        end
        start_by_soft();
        total++;
        if (obs !== 8'h00) begin
            bad++;
            $display("FAIL recovery_pulse got=%b exp=%b", obs, 8'h00);
        end
        plan(5, 5, 5, 0, '0);
        for (int t = 1; t <= last_edge(); t++) begin
            step(t);
            total++;
            if (obs !== expect_at(t)) begin
                bad++;
                $display("FAIL recovery t=%0d got=%b exp=%b", t, obs, expect_at(t));
            end
        end
    endtask

    // Soft request held for several edges: hold counting restarts each time.
    task automatic test_soft_hold();
        int k;
        k = $urandom_range(2, 6);
        for (int j = 0; j < k; j++) begin
            start_by_soft();
            total++;
            if (obs !== 8'h00) begin
                bad++;
                $display("FAIL soft_hold j=%0d got=%b exp=%b", j, obs, 8'h00);
            end
        end
        plan(2, 7, 1, 0, '0);
        for (int t = 1; t <= last_edge(); t++) begin
            step(t);
            total++;
            if (obs !== expect_at(t)) begin
                bad++;
                $display("FAIL soft_hold t=%0d got=%b exp=%b", t, obs, expect_at(t));
            end
        end
    endtask

    task automatic test_mid_reset();
        start_by_reset();
        plan(5, 5, 5, 0, '0);
        for (int t = 1; t <= rise[1] + 3; t++) begin
            step(t);
            total++;
            if (obs !== expect_at(t)) begin
                bad++;
                $display("FAIL mid_pre t=%0d got=%b exp=%b", t, obs, expect_at(t));
            end
        end
        @(negedge clk);
        reset_n        = 1'b0;
        soft_reset_req = 1'b0;
        stage_ready    = '1;
        @(posedge clk);
        #1;
        total++;
        if (obs !== 8'h00) begin
            bad++;
            $display("FAIL mid_reset got=%b exp=%b", obs, 8'h00);
        end
        plan(6, 2, 7, 0, '0);
        for (int t = 1; t <= last_edge(); t++) begin
            step(t);
            total++;
            if (obs !== expect_at(t)) begin
                bad++;
                $display("FAIL mid_after t=%0d got=%b exp=%b", t, obs, expect_at(t));
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                start_by_reset();
            end else begin
                start_by_soft();
            end
            total++;
            if (obs !== 8'h00) begin
                bad++;
                $display("FAIL random_start it=%0d got=%b exp=%b", it, obs, 8'h00);
            end
            plan($urandom_range(0, 36), $urandom_range(0, 36), $urandom_range(0, 36),
                 $urandom_range(1, 6),
                 ($urandom_range(0, 1) == 1) ? N'($urandom_range(1, 7)) : '0);
            for (int t = 1; t <= last_edge(); t++) begin
                step(t);
                total++;
                if (obs !== expect_at(t)) begin
                    bad++;
                    $display("FAIL random it=%0d t=%0d got=%b exp=%b",
                             it, t, obs, expect_at(t));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_timeout();
        test_boundary();
        test_runtime_drop();
        test_recovery();
        test_soft_hold();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
